uart_result_scheduler: RTL and testbench
========================================

# uart_result_scheduler

Sequences and shares the 16-bit serial transmitter (`uart_tx_16`) between `N_CORES` Mandelbrot compute cores. It accepts finished results from the cores with a valid/ack handshake, chosen by round-robin. It sends each result as a two-word frame: a header word carrying the core ID, then the result word. It sits between the core array and the single `uart_tx_16` instance, and it alone drives that transmitter's `i_Tx_DV` / `i_Tx_Byte`.

## Interface
Parameters:
- `N_CORES`, 4: number of requesting cores, 2..16.
- `HDR_TAG`, 8'hA5: upper byte of every header word.

Ports:
- `i_Clock`  in  1  system clock, single domain.
- `i_Reset_n`  in  1  asynchronous, active-low reset.
- `i_Req_Valid`  in  N_CORES  core k holds a result; held until acked.
- `i_Req_Data`  in  16*N_CORES  result of core k at bits [16k+15:16k]; stable while valid.
- `o_Req_Ack`  out  N_CORES  one-cycle pulse; data of core k captured.
- `o_Tx_DV`  out  1  to `uart_tx_16` `i_Tx_DV`; one-cycle pulse.
- `o_Tx_Word`  out  16  to `uart_tx_16` `i_Tx_Byte`; held stable from the DV cycle until the next DV.
- `i_Tx_Active`  in  1  from `uart_tx_16` `o_Tx_Active`.
- `i_Tx_Done`  in  1  from `uart_tx_16` `o_Tx_Done`. It is high for 2 consecutive cycles per word.
- `o_Busy`  out  1  high while a frame is in progress (any state other than IDLE).
- `o_Frame_Count`  out  16  number of completed frames; wraps from 0xFFFF to 0.

## Operation
- Every output is registered. Reset values: `o_Req_Ack`=0, `o_Tx_DV`=0, `o_Tx_Word`=0, `o_Busy`=0, `o_Frame_Count`=0, state=IDLE, RR pointer=N_CORES-1, latched data=0.
- Transmitter free condition: `i_Tx_Active`=0 and `i_Tx_Done`=0. DV is never issued otherwise, because `uart_tx_16` ignores DV outside its idle state.
- States:
  - IDLE: if free and any valid, pick core k, starting the search at pointer+1 mod N_CORES. Latch `i_Req_Data[k]`, set pointer=k, pulse `o_Req_Ack[k]`, load `o_Tx_Word`={HDR_TAG, 4'b0, k[3:0]}, pulse `o_Tx_DV`, go to WAIT_HDR.
  - WAIT_HDR: wait for `i_Tx_Done`=1, then go to GAP_HDR.
  - GAP_HDR: wait for free, then load `o_Tx_Word`=latched data, pulse `o_Tx_DV`, go to WAIT_DATA.
  - WAIT_DATA: wait for `i_Tx_Done`=1, then go to GAP_DATA.
  - GAP_DATA: wait for free, then increment `o_Frame_Count` and go to IDLE.
- Cores are not sampled outside IDLE. A valid that rises mid-frame waits and is never lost.
- Simultaneous valids: the lowest index at or after pointer+1 (cyclic) wins.
- If a core drops valid without an ack, that is a protocol violation with no defined behaviour. The bench asserts it never happens.
- Reset mid-frame: the frame is abandoned and no ack is repeated. `uart_tx_16` has no reset and may still be sending. After reset the scheduler waits for free in IDLE before the next DV, so a stale word completes unharmed.
- Unknown state encoding recovers to IDLE.

## Timing
- Grant latency: valid and free at cycle t gives ack and header DV both at t+1.
- Header to data: `i_Tx_Done` first high at cycle d gives data DV at d+2, the first cycle with Done=0.
- Frame completion: the data word's Done first high at e gives the `o_Frame_Count` increment at e+2 and IDLE at e+2. A new header DV can follow at e+3 at the earliest.
- Frame length is 2 × 18 × CLKS_PER_BIT cycles plus about 6 overhead cycles.
- Back-to-back throughput: one frame per grant. There is no pipelining of the next grant during the current frame.

## Structure
- Shared package `mandel_uart_pkg` holds:
  - the state enum (IDLE, WAIT_HDR, GAP_HDR, WAIT_DATA, GAP_DATA, 3-bit);
  - the `HDR_TAG` default;
  - the header-field layout constants (tag [15:8], ID [3:0]).
- One sub-module: `rr_pick`, a combinational round-robin selector (request vector plus pointer in; one-hot grant and index out). It is unit-tested separately.
- The top level is instantiated next to `uart_tx_16` in the top design.

## Test plan
Bench instantiates `uart_tx_16` with CLKS_PER_BIT=4, N_CORES=4, and a serial decoder on `o_Tx_Serial`.
- Single request: core 2 valid with 0x1234 → ack[2] at t+1, serial words 0xA502 then 0x1234, `o_Frame_Count`=1, `o_Busy` low after.
- All four valid at once → frames in order core 0,1,2,3. Each ack fires exactly once, and 4 frames are counted.
- Fairness: cores 1 and 3 re-assert valid immediately after each ack, for 6 frames → IDs alternate 1,3,1,3,1,3.
- DV gating: check on every cycle that `o_Tx_DV`=1 only when `i_Tx_Active`=0 and `i_Tx_Done`=0. Check that data DV lands exactly 2 cycles after header Done rises.
- Reset mid-frame: assert `i_Reset_n`=0 for 3 cycles during the header word → outputs at reset values. The next DV does not come before `uart_tx_16` finishes, and the next frame decodes correctly.
- Counter wrap: force `o_Frame_Count` to 0xFFFF, complete one frame → the count reads 0x0000.

Source files
------------

// File: rtl/mandel_uart_pkg.sv
// Shared definitions for the Mandelbrot result path to the 16-bit UART transmitter.
// Holds the scheduler state encoding, the default header tag and the header word layout.
// Header word: tag in [15:8], zero padding in [7:4], core ID in [3:0].
package mandel_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HDR  = 3'd1,
    ST_GAP_HDR   = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_GAP_DATA  = 3'd4
  } sched_state_t;

  localparam logic [7:0] HDR_TAG_DEFAULT = 8'hA5;

  localparam int HDR_TAG_MSB = 15;
  localparam int HDR_TAG_LSB = 8;
  localparam int HDR_ID_MSB  = 3;
  localparam int HDR_ID_LSB  = 0;

  function automatic logic [15:0] make_hdr(input logic [7:0] tag, input logic [3:0] id);
    logic [15:0] w;
    w = '0;
    w[HDR_TAG_MSB:HDR_TAG_LSB] = tag;
    w[HDR_ID_MSB:HDR_ID_LSB]   = id;
    return w;
  endfunction

endpackage

// File: rtl/uart_result_scheduler_rr_pick.sv
// rr_pick: combinational round-robin selector; lowest index at or after ptr+1 (cyclic) wins.
// Latency: none (pure combinational). Backpressure: none; the caller decides when to use the grant.
// Ports: req (request vector), ptr (last granted index), grant (one-hot), idx (binary), any (some request).
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   ptr,
  output logic [N-1:0] grant,
  output logic [3:0]   idx,
  output logic         any
);

  always_comb begin
    int ptr_i;
    int rank;
    int best;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    best  = N;
    rank  = 0;
    ptr_i = int'(ptr);
    // rank = cyclic distance from ptr+1; the smallest rank among requesters wins
    for (int k = 0; k < N; k++) begin
      if (k > ptr_i) rank = k - ptr_i - 1;
      else           rank = k + N - ptr_i - 1;
      if (req[k] && (rank < best)) begin
        best = rank;
        idx  = 4'(k);
        any  = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      grant[k] = any && (idx == 4'(k));
    end
  end

endmodule

// File: rtl/uart_result_scheduler.sv
// uart_result_scheduler: round-robin sharing of one uart_tx_16 between N_CORES result producers;
// each grant sends a two-word frame {HDR_TAG, 4'b0, id} then the result word.
// Latency: ack + header DV one cycle after valid&free; backpressure: waits on i_Tx_Active/i_Tx_Done.
// Ports: i_Clock/i_Reset_n (async low); i_Req_Valid/i_Req_Data/o_Req_Ack core side;
//        o_Tx_DV/o_Tx_Word/i_Tx_Active/i_Tx_Done transmitter side; o_Busy, o_Frame_Count status.
module uart_result_scheduler
  import mandel_uart_pkg::*;
#(
  parameter int         N_CORES = 4,
  parameter logic [7:0] HDR_TAG = HDR_TAG_DEFAULT
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic [N_CORES-1:0]     i_Req_Valid,
  input  logic [16*N_CORES-1:0]  i_Req_Data,
  output logic [N_CORES-1:0]     o_Req_Ack,
  output logic                   o_Tx_DV,
  output logic [15:0]            o_Tx_Word,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done,
  output logic                   o_Busy,
  output logic [15:0]            o_Frame_Count
);

  sched_state_t        state;
  logic [3:0]          rr_ptr;
  logic [15:0]         data_q;
  logic                done_q;
  logic [N_CORES-1:0]  pick_grant;
  logic [3:0]          pick_idx;
  logic                pick_any;
  logic [15:0]         pick_data;
  logic                tx_free;
  logic                tx_free_next;

  rr_pick #(.N(N_CORES)) u_rr_pick (
    .req   (i_Req_Valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < N_CORES; k++) begin
      if (pick_grant[k]) pick_data = i_Req_Data[16*k +: 16];
    end
  end

  assign tx_free = !i_Tx_Active && !i_Tx_Done;

  // Done is a fixed two-cycle pulse. Seeing it on its second cycle means the
  // transmitter is back in idle with Done low next cycle, exactly when a
  // registered DV issued now becomes visible. IDLE uses the strict form so
  // that after a reset it never races a word still in flight.
  assign tx_free_next = !i_Tx_Active && (!i_Tx_Done || done_q);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= 4'(N_CORES - 1);
      data_q        <= '0;
      done_q        <= 1'b0;
      o_Req_Ack     <= '0;
      o_Tx_DV       <= 1'b0;
      o_Tx_Word     <= '0;
      o_Busy        <= 1'b0;
      o_Frame_Count <= '0;
    end else begin
      o_Req_Ack <= '0;
      o_Tx_DV   <= 1'b0;
      done_q    <= i_Tx_Done;
      case (state)
        ST_IDLE: begin
          if (tx_free && pick_any) begin
            data_q    <= pick_data;
            rr_ptr    <= pick_idx;
            o_Req_Ack <= pick_grant;
            o_Tx_Word <= make_hdr(HDR_TAG, pick_idx);
            o_Tx_DV   <= 1'b1;
            o_Busy    <= 1'b1;
            state     <= ST_WAIT_HDR;
          end
        end
        ST_WAIT_HDR: begin
          if (i_Tx_Done) state <= ST_GAP_HDR;
        end
        ST_GAP_HDR: begin
          if (tx_free_next) begin
            o_Tx_Word <= data_q;
            o_Tx_DV   <= 1'b1;
            state     <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (i_Tx_Done) state <= ST_GAP_DATA;
        end
        ST_GAP_DATA: begin
          if (tx_free_next) begin
            o_Frame_Count <= o_Frame_Count + 16'd1;
            o_Busy        <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_result_scheduler.sv
// Bench for uart_result_scheduler with a behavioural 16-bit UART transmitter and serial decoder.
// Expected words are queued when requests are raised and compared as the decoder recovers them.
// Directed steps: reset, all-four, fairness, single-request timing, counter wrap, reset mid-frame.
module tb_uart_result_scheduler;

  localparam int N        = 4;
  localparam int CPB      = 4;
  localparam int WORD_CYC = 18 * CPB;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [15:0]       core_data [N];
  logic [16*N-1:0]   req_data;
  logic [N-1:0]      req_ack;
  logic              tx_dv;
  logic [15:0]       tx_word;
  logic              tx_active = 1'b0;
  logic              tx_done   = 1'b0;
  logic              busy;
  logic [15:0]       frame_count;

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_count;
  int          ack_cnt [N];
  int          reissue_left [N];
  int          round_no [N];

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int k = 0; k < N; k++) req_data[16*k +: 16] = core_data[k];
  end

  uart_result_scheduler #(.N_CORES(N), .HDR_TAG(8'hA5)) dut (
    .i_Clock       (clk),
    .i_Reset_n     (rst_n),
    .i_Req_Valid   (req_valid),
    .i_Req_Data    (req_data),
    .o_Req_Ack     (req_ack),
    .o_Tx_DV       (tx_dv),
    .o_Tx_Word     (tx_word),
    .i_Tx_Active   (tx_active),
    .i_Tx_Done     (tx_done),
    .o_Busy        (busy),
    .o_Frame_Count (frame_count)
  );

  // Transmitter model: no reset; DV accepted only in idle; Done high two cycles.
  int          tx_st = 0;
  int          tx_cnt = 0;
  logic [15:0] tx_shift = '0;
  logic        tx_serial;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    case (tx_st)
      0: begin
        tx_done <= 1'b0;
        if (tx_dv === 1'b1) begin
          tx_shift  <= tx_word;
          tx_active <= 1'b1;
          tx_cnt    <= 0;
          tx_st     <= 1;
        end
      end
      1: begin
        if (tx_cnt == WORD_CYC - 1) begin
          tx_active <= 1'b0;
          tx_done   <= 1'b1;
          tx_st     <= 2;
        end else begin
          tx_cnt <= tx_cnt + 1;
        end
      end
      default: begin
        tx_done <= 1'b1;
        tx_st   <= 0;
      end
    endcase
  end

  always_comb begin
    int bi;
    bi = tx_cnt / CPB;
    tx_serial = 1'b1;
    if (tx_st == 1) begin
      if (bi == 0)       tx_serial = 1'b0;
      else if (bi <= 16) tx_serial = tx_shift[4'(bi - 1)];
    end
  end

  // Serial decoder: mid-bit sampling, LSB first, then scoreboard compare.
  initial begin
    logic [15:0] w;
    logic [15:0] e;
    w = '0;
    forever begin
      @(negedge tx_serial);
      repeat (CPB / 2) @(posedge clk);
      for (int b = 0; b < 16; b++) begin
        repeat (CPB) @(posedge clk);
        #1;
        w[4'(b)] = tx_serial;
      end
      repeat (CPB) @(posedge clk);
      #1;
      checks++;
      assert (tx_serial === 1'b1) else begin
        errors++; $error("FAIL stop_bit observed=%b expected=1", tx_serial);
      end
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++; $error("FAIL unexpected_word observed=%h expected=none", w);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (w === e) else begin
          errors++; $error("FAIL serial_word observed=%h expected=%h", w, e);
        end
      end
    end
  end

  // DV may only be seen while the transmitter is idle with Done low.
  always @(posedge clk) begin
    #1;
    if (tx_dv === 1'b1) begin
      checks++;
      assert (tx_active === 1'b0 && tx_done === 1'b0) else begin
        errors++; $error("FAIL dv_gating active=%b done=%b expected active=0 done=0", tx_active, tx_done);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] hdr(input int k);
    return {8'hA5, 4'h0, 4'(k)};
  endfunction

  function automatic logic [15:0] mk_data(input int k, input int r);
    return {4'(k + 1), 4'h7, 8'(r * 16 + k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_agents();
    for (int k = 0; k < N; k++) begin
      ack_cnt[k] = 0; reissue_left[k] = 0; round_no[k] = 0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk16({tag, "_ack"},   16'(req_ack), 16'h0);
    chk16({tag, "_dv"},    16'(tx_dv), 16'h0);
    chk16({tag, "_word"},  tx_word, 16'h0);
    chk16({tag, "_busy"},  16'(busy), 16'h0);
    chk16({tag, "_count"}, frame_count, 16'h0);
  endtask

  // Plays the cores: drop (or re-raise with fresh data) on ack, until all queued words are out.
  task automatic service(input int budget);
    bit done_ok;
    done_ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        if (req_ack[2'(k)] === 1'b1) begin
          checks++;
          assert (req_valid[2'(k)] === 1'b1) else begin
            errors++; $error("FAIL ack_without_valid core=%0d observed=0 expected=1", k);
          end
          ack_cnt[k]++;
          if (reissue_left[k] > 0) begin
            reissue_left[k]--;
            round_no[k]++;
            core_data[k] = mk_data(k, round_no[k]);
          end else begin
            req_valid[2'(k)] = 1'b0;
          end
        end
      end
      if (exp_q.size() == 0 && busy === 1'b0 && req_valid == '0) begin
        done_ok = 1'b1;
        break;
      end
    end
    checks++;
    assert (done_ok) else begin
      errors++; $error("FAIL service_timeout observed=pending expected=idle within %0d cycles", budget);
    end
  endtask

  task automatic wait_done(input int budget, output int at);
    bit ok;
    ok = 1'b0; at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (tx_done === 1'b1) begin ok = 1'b1; at = cycle; break; end
    end
    checks++;
    assert (ok) else begin errors++; $error("FAIL wait_done observed=timeout expected=done"); end
  endtask

  task automatic wait_dv(input int budget, output int at);
    bit ok;
    ok = 1'b0; at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (tx_dv === 1'b1) begin ok = 1'b1; at = cycle; break; end
    end
    checks++;
    assert (ok) else begin errors++; $error("FAIL wait_dv observed=timeout expected=dv"); end
  endtask

  initial begin
    int t_d;
    int t_v;
    bit ok;
    bit seen_done;

    rst_n = 1'b0;
    req_valid = '0;
    for (int k = 0; k < N; k++) core_data[k] = '0;
    clear_agents();
    exp_count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // All four at once: pointer starts at N-1, so order is 0,1,2,3
    for (int k = 0; k < N; k++) begin
      core_data[k] = mk_data(k, 0);
      exp_q.push_back(hdr(k));
      exp_q.push_back(mk_data(k, 0));
    end
    req_valid = '1;
    service(1500);
    exp_count = exp_count + 16'd4;
    chk16("count_after_all4", frame_count, exp_count);
    for (int k = 0; k < N; k++) chk_int("ack_once_all4", ack_cnt[k], 1);

    // Fairness: cores 1 and 3 re-raise after every ack
    clear_agents();
    reissue_left[1] = 2;
    reissue_left[3] = 2;
    core_data[1] = mk_data(1, 0);
    core_data[3] = mk_data(3, 0);
    for (int j = 0; j < 6; j++) begin
      exp_q.push_back(hdr((j % 2 == 0) ? 1 : 3));
      exp_q.push_back(mk_data((j % 2 == 0) ? 1 : 3, j / 2));
    end
    req_valid = 4'b1010;
    service(2500);
    exp_count = exp_count + 16'd6;
    chk16("count_after_fair", frame_count, exp_count);
    chk_int("fair_acks_core1", ack_cnt[1], 3);
    chk_int("fair_acks_core3", ack_cnt[3], 3);

    // Single request on core 2 with cycle-exact timing
    core_data[2] = 16'h1234;
    exp_q.push_back(16'hA502);
    exp_q.push_back(16'h1234);
    req_valid[2] = 1'b1;
    tick();
    chk16("single_ack", 16'(req_ack), 16'h0004);
    chk16("single_hdr_dv", 16'(tx_dv), 16'h1);
    chk16("single_hdr_word", tx_word, 16'hA502);
    chk16("single_busy", 16'(busy), 16'h1);
    req_valid[2] = 1'b0;
    tick();
    chk16("single_ack_pulse", 16'(req_ack), 16'h0);
    chk16("single_dv_pulse", 16'(tx_dv), 16'h0);
    wait_done(300, t_d);
    wait_dv(20, t_v);
    chk_int("data_dv_delay", t_v - t_d, 2);
    chk16("single_data_word", tx_word, 16'h1234);
    wait_done(300, t_d);
    tick();
    chk16("count_at_e1", frame_count, exp_count);
    tick();
    exp_count = exp_count + 16'd1;
    chk16("count_at_e2", frame_count, exp_count);
    chk16("busy_after_frame", 16'(busy), 16'h0);
    chk_int("single_drained", exp_q.size(), 0);

    // Counter wrap
    force dut.o_Frame_Count = 16'hFFFF;
    tick();
    release dut.o_Frame_Count;
    exp_count = 16'hFFFF;
    chk16("count_forced", frame_count, exp_count);
    core_data[0] = 16'h0F0F;
    exp_q.push_back(16'hA500);
    exp_q.push_back(16'h0F0F);
    req_valid[0] = 1'b1;
    service(800);
    exp_count = exp_count + 16'd1;
    chk16("count_wrap", frame_count, exp_count);

    // Reset during the header word: header still goes out, data never does
    core_data[0] = 16'hBEEF;
    exp_q.push_back(16'hA500);
    req_valid[0] = 1'b1;
    tick();
    chk16("midrst_ack", 16'(req_ack), 16'h0001);
    req_valid[0] = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_count = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    core_data[1] = 16'h5A5A;
    exp_q.push_back(16'hA501);
    exp_q.push_back(16'h5A5A);
    req_valid[1] = 1'b1;
    seen_done = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx_done === 1'b1) seen_done = 1'b1;
      if (tx_dv === 1'b1) begin ok = 1'b1; break; end
    end
    chk16("post_reset_dv_seen", 16'(ok), 16'h1);
    chk16("post_reset_waited_done", 16'(seen_done), 16'h1);
    chk16("post_reset_ack", 16'(req_ack), 16'h0002);
    req_valid[1] = 1'b0;
    service(800);
    exp_count = exp_count + 16'd1;
    chk16("count_after_reset_frame", frame_count, exp_count);
    chk_int("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
